// File: rtl/digit_renderer.sv
// digit_renderer: renders a latched NUM_DIGITS-wide BCD value as scaled glyphs.
// Horizontal position is tracked with counters rather than a divider. Glyph rows
// come from an external combinational 8x12 ROM. pixel_on/pixel_valid appear two
// clocks after the matching hcount/vcount/video_active.
module digit_renderer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ORIGIN_X   = 16,
    parameter int unsigned ORIGIN_Y   = 16,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned COORD_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COORD_W-1:0]      hcount,
    input  logic [COORD_W-1:0]      vcount,
    input  logic                    video_active,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic                    value_valid,
    output logic [3:0]              decimal,
    output logic [3:0]              bitmap_row_index,
    input  logic [7:0]              bitmap_row,
    output logic                    pixel_on,
    output logic                    pixel_valid
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SUB_W-1:0]   SUB_LAST    = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST    = DIG_W'(NUM_DIGITS - 1);
    localparam logic [3:0]         GAP_COL     = 4'd8;
    localparam logic [COORD_W-1:0] X0          = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] Y0          = COORD_W'(ORIGIN_Y);
    localparam logic [COORD_W-1:0] ROWS_SCALED = COORD_W'(12 << SCALE_LOG2);

    // Value holding registers
    logic [VAL_W-1:0] pending_q, pending_d;
    logic [VAL_W-1:0] display_q, display_d;

    // Horizontal tracker
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       col_q, col_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             run_q, run_d;

    // Tracker view of the current cycle
    logic             load;
    logic             cur_run;
    logic [SUB_W-1:0] cur_sub;
    logic [3:0]       cur_col;
    logic [DIG_W-1:0] cur_dig;

    // Vertical / glyph decode
    logic [COORD_W-1:0] r_off;
    logic               in_y;
    logic [3:0]         row;
    logic [3:0]         sel_nib;
    logic               glyph_hit;

    // Stage 1
    logic [3:0] decimal_q, decimal_d;
    logic [3:0] row_idx_q, row_idx_d;
    logic       hit_q;
    logic [2:0] col1_q;
    logic       va1_q;

    // Stage 2
    logic pixel_on_q, pixel_on_d;
    logic pixel_valid_q;

    // Tear-free capture: frame_start copies the pending value as it was before this edge
    always_comb begin
        pending_d = pending_q;
        display_d = display_q;
        if (value_valid) begin
            pending_d = value_bcd;
        end
        if (frame_start) begin
            display_d = pending_q;
        end
    end

    // Pending and display value registers, blank on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '1;
            display_q <= '1;
        end else begin
            pending_q <= pending_d;
            display_q <= display_d;
        end
    end

    // Tracker: the load cycle is itself position (0,0,0), so registers hold the next pixel's position
    always_comb begin
        load    = video_active && (hcount == X0);
        cur_run = video_active && (load || run_q);
        cur_sub = load ? '0 : sub_q;
        cur_col = load ? '0 : col_q;
        cur_dig = load ? '0 : dig_q;

        sub_d = '0;
        col_d = '0;
        dig_d = '0;
        run_d = 1'b0;
        if (cur_run) begin
            run_d = 1'b1;
            sub_d = cur_sub;
            col_d = cur_col;
            dig_d = cur_dig;
            if (cur_sub == SUB_LAST) begin
                sub_d = '0;
                if (cur_col == GAP_COL) begin
                    col_d = '0;
                    if (cur_dig == DIG_LAST) begin
                        dig_d = '0;
                        run_d = 1'b0;
                    end else begin
                        dig_d = cur_dig + 1'b1;
                    end
                end else begin
                    col_d = cur_col + 4'd1;
                end
            end else begin
                sub_d = cur_sub + 1'b1;
            end
        end
    end

    // Horizontal tracker state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
            col_q <= '0;
            dig_q <= '0;
            run_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
            col_q <= col_d;
            dig_q <= dig_d;
            run_q <= run_d;
        end
    end

    // Vertical window, digit select and glyph lookup request
    always_comb begin
        r_off = vcount - Y0;
        in_y  = (vcount >= Y0) && (r_off < ROWS_SCALED);
        row   = 4'(r_off >> SCALE_LOG2);

        sel_nib = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cur_dig == DIG_W'(i)) begin
                sel_nib = display_q[4*(NUM_DIGITS-1-i) +: 4];
            end
        end

        glyph_hit = cur_run && in_y && (cur_col < GAP_COL) && (sel_nib <= 4'd9);
        decimal_d = glyph_hit ? sel_nib : 4'hF;
        row_idx_d = glyph_hit ? row : 4'd0;
    end

    // Stage 1: ROM address plus the bits needed to pick the pixel next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decimal_q <= 4'hF;
            row_idx_q <= 4'd0;
            hit_q     <= 1'b0;
            col1_q    <= 3'd0;
            va1_q     <= 1'b0;
        end else begin
            decimal_q <= decimal_d;
            row_idx_q <= row_idx_d;
            hit_q     <= glyph_hit;
            col1_q    <= cur_col[2:0];
            va1_q     <= video_active;
        end
    end

    // Pixel select from the returned glyph row, bit 7 is the leftmost column
    always_comb begin
        pixel_on_d = hit_q & va1_q & bitmap_row[3'd7 - col1_q];
    end

    // Stage 2: output pixel and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_on_q    <= pixel_on_d;
            pixel_valid_q <= va1_q;
        end
    end

    assign decimal          = decimal_q;
    assign bitmap_row_index = row_idx_q;
    assign pixel_on         = pixel_on_q;
    assign pixel_valid      = pixel_valid_q;

endmodule
